cpu_bus_capture: RTL

- Front-end stage sitting directly upstream of the mapper multiplexer, in the `clk` domain.
- Synchronizes the asynchronous NES CPU bus (M2, address incl. ROMSEL-derived A15, R/W, data) into `clk`.
- Deglitches M2 and detects its edges; emits one read or write transaction per CPU cycle over a valid/ready handshake.
- Also produces the SDRAM refresh pulse after each M2 fall, replacing ad-hoc edge logic at top level.

---
 rtl/cart_bus_pkg.sv | 19 +
 rtl/cpu_bus_capture_if.sv | 13 +
 rtl/cpu_bus_capture_sync_filter.sv | 47 ++++
 rtl/cpu_bus_capture.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
// Shared types for the cartridge CPU bus front-end.
package cart_bus_pkg;

    localparam int CPU_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HIGH,
        LOW
    } bus_state_t;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0] addr;
        logic [7:0]            data;
        logic                  rw;
    } cpu_txn_t;

endpackage

// File: rtl/cpu_bus_capture_if.sv
// Valid/ready transaction channel from the CPU bus capture stage to the mapper mux.
interface cpu_txn_if;
    import cart_bus_pkg::*;

    logic                  txn_valid;
    logic                  txn_ready;
    logic [CPU_ADDR_W-1:0] txn_addr;
    logic [7:0]            txn_data;
    logic                  txn_rw;

    modport master (output txn_valid, txn_addr, txn_data, txn_rw, input txn_ready);
    modport slave  (input txn_valid, txn_addr, txn_data, txn_rw, output txn_ready);
endinterface

// File: rtl/cpu_bus_capture_sync_filter.sv
// Multi-flop synchronizer plus run-length deglitcher; rise/fall/glitch are
// combinational and flag the cycle in which the filtered level is about to change.
module sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic glitch
);
    logic [SYNC_STAGES-1:0] sync;
    logic [3:0]             cnt;
    logic                   synced;
    logic                   differ;
    logic                   flip;

    assign synced = sync[SYNC_STAGES-1];
    assign differ = synced != level;
    assign flip   = differ && (cnt == 4'(FILTER_CYCLES - 1));
    assign rise   = flip && !level;
    assign fall   = flip && level;
    // A run that ends before reaching the threshold was a glitch.
    assign glitch = !differ && (cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else if (differ) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/cpu_bus_capture.sv
// NES CPU bus capture: synchronizes the async bus, tracks M2 phases and emits
// one transaction per CPU cycle plus a post-fall SDRAM refresh pulse.
// Optional statistics counters: define CPU_BUS_STATS_EN.
module cpu_bus_capture
    import cart_bus_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int RD_DELAY      = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  m2,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [7:0]            cpu_data,
    input  logic                  cpu_rw,
    cpu_txn_if.master             txn,
    output logic                  m2_level,
    output logic                  refresh,
    output logic                  overflow
`ifdef CPU_BUS_STATS_EN
    ,
    output logic [15:0]           stat_rd_cnt,
    output logic [15:0]           stat_wr_cnt,
    output logic [7:0]            stat_glitch_cnt
`endif
);
    logic m2_rise, m2_fall, m2_glitch;

    sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_m2_filter (
        .clk   (clk),
        .nreset(nreset),
        .din   (m2),
        .level (m2_level),
        .rise  (m2_rise),
        .fall  (m2_fall),
        .glitch(m2_glitch)
    );

    // Address/data/rw only need plain sync flops; M2 phase decides when to sample them.
    cpu_txn_t                   bus_raw;
    cpu_txn_t [SYNC_STAGES-1:0] bus_sync;
    cpu_txn_t                   bus;

    assign bus_raw = '{addr: cpu_addr, data: cpu_data, rw: cpu_rw};
    assign bus     = bus_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            bus_sync <= '0;
        end else begin
            bus_sync[0] <= bus_raw;
            for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
        end
    end

    bus_state_t            state, state_nxt;
    logic [7:0]            dly;
    logic [CPU_ADDR_W-1:0] cap_addr;
    logic                  cap_rw;
    logic                  load_dly, latch_cap, emit_rd, emit_wr;

    always_ff @(posedge clk) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (m2_rise) state_nxt = SETTLE;
            SETTLE:  if (m2_fall) state_nxt = IDLE;
                     else if (dly == 8'd0) state_nxt = HIGH;
            HIGH:    if (m2_fall) state_nxt = LOW;
            LOW:     state_nxt = m2_rise ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_dly  = m2_rise && (state == IDLE || state == LOW);
        latch_cap = (state == SETTLE) && !m2_fall && (dly == 8'd0);
        emit_rd   = latch_cap && bus.rw;
        emit_wr   = (state == LOW) && !cap_rw;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            dly           <= '0;
            cap_addr      <= '0;
            cap_rw        <= 1'b1;
            txn.txn_valid <= 1'b0;
            txn.txn_addr  <= '0;
            txn.txn_data  <= '0;
            txn.txn_rw    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (load_dly)                         dly <= 8'(RD_DELAY);
            else if (state == SETTLE && dly != 0) dly <= dly - 8'd1;
            if (latch_cap) begin
                cap_addr <= bus.addr;
                cap_rw   <= bus.rw;
            end
            if (emit_rd || emit_wr) begin
                txn.txn_valid <= 1'b1;
                txn.txn_addr  <= emit_rd ? bus.addr : cap_addr;
                txn.txn_data  <= emit_rd ? 8'h00 : bus.data;
                txn.txn_rw    <= emit_rd;
                if (txn.txn_valid && !txn.txn_ready) overflow <= 1'b1;
            end else if (txn.txn_valid && txn.txn_ready) begin
                txn.txn_valid <= 1'b0;
            end
        end
    end

    // Refresh fires two cycles after the filtered fall; back-to-back falls merge.
    logic [1:0] ref_pipe;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            ref_pipe <= '0;
            refresh  <= 1'b0;
        end else begin
            ref_pipe <= {ref_pipe[0], m2_fall};
            refresh  <= ref_pipe[1] && !refresh;
        end
    end

`ifdef CPU_BUS_STATS_EN
    always_ff @(posedge clk) begin
        if (!nreset) begin
            stat_rd_cnt     <= '0;
            stat_wr_cnt     <= '0;
            stat_glitch_cnt <= '0;
        end else begin
            if (emit_rd)   stat_rd_cnt     <= stat_rd_cnt + 16'd1;
            if (emit_wr)   stat_wr_cnt     <= stat_wr_cnt + 16'd1;
            if (m2_glitch) stat_glitch_cnt <= stat_glitch_cnt + 8'd1;
        end
    end
`else
    logic unused_glitch;
    assign unused_glitch = m2_glitch;
`endif
endmodule
